dual_fetch_queue: RTL and testbench



---
 rtl/dual_fetch_queue_if.sv | 39 +++
 rtl/dual_fetch_queue.sv | 93 +++++++++
 tb/tb_dual_fetch_queue.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dual_fetch_queue_if.sv
// Handshake bundle between the fetch unit (master) and the dual fetch queue (slave).
// The DEPTH parameter only sizes the occupancy count.
interface dual_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            in_valid_a;
  logic [XLEN-1:0] in_instr_a;
  logic [XLEN-1:0] in_pc_a;
  logic            in_valid_b;
  logic [XLEN-1:0] in_instr_b;
  logic [XLEN-1:0] in_pc_b;
  logic            in_ready;
  logic [1:0]      pop_cnt;
  logic            out_valid_a;
  logic [XLEN-1:0] out_instr_a;
  logic [XLEN-1:0] out_pc_a;
  logic            out_valid_b;
  logic [XLEN-1:0] out_instr_b;
  logic [XLEN-1:0] out_pc_b;
  logic [CW-1:0]   count;

  modport master (
    output flush, in_valid_a, in_instr_a, in_pc_a,
           in_valid_b, in_instr_b, in_pc_b, pop_cnt,
    input  in_ready, out_valid_a, out_instr_a, out_pc_a,
           out_valid_b, out_instr_b, out_pc_b, count
  );

  modport slave (
    input  flush, in_valid_a, in_instr_a, in_pc_a,
           in_valid_b, in_instr_b, in_pc_b, pop_cnt,
    output in_ready, out_valid_a, out_instr_a, out_pc_a,
           out_valid_b, out_instr_b, out_pc_b, count
  );
endinterface

// File: rtl/dual_fetch_queue.sv
// In-order circular instruction buffer: up to two pushes and two pops per cycle,
// exposing the two oldest entries to the dual decoders, with flush for redirects.
module dual_fetch_queue #(
  parameter int              DEPTH     = 8,
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst_n,
  dual_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr_p1;
  logic [PW-1:0]   wr_ptr_p1;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   pop_req;
  logic [CW-1:0]   pop_n;
  logic            ready;
  logic            push_ok;
  logic [XLEN-1:0] first_instr;
  logic [XLEN-1:0] first_pc;

  assign rd_ptr_p1 = rd_ptr + PW'(1);
  assign wr_ptr_p1 = wr_ptr + PW'(1);

  // Readiness looks only at registered occupancy, so a same-cycle pop never helps.
  assign ready   = (count_q <= CW'(DEPTH - 2));
  assign push_ok = ready && !bus.flush;
  assign push_n  = push_ok ? (CW'(bus.in_valid_a) + CW'(bus.in_valid_b)) : '0;
  assign pop_req = bus.pop_cnt[1] ? CW'(2) : CW'(bus.pop_cnt[0]);
  assign pop_n   = (pop_req > count_q) ? count_q : pop_req;

  // A lone lane-B push lands in the slot lane A would have used.
  assign first_instr = bus.in_valid_a ? bus.in_instr_a : bus.in_instr_b;
  assign first_pc    = bus.in_valid_a ? bus.in_pc_a    : bus.in_pc_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr  <= rd_ptr + pop_n[PW-1:0];
      wr_ptr  <= wr_ptr + push_n[PW-1:0];
      count_q <= count_q + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok && (bus.in_valid_a || bus.in_valid_b)) begin
      instr_mem[wr_ptr] <= first_instr;
      pc_mem[wr_ptr]    <= first_pc;
      if (bus.in_valid_a && bus.in_valid_b) begin
        instr_mem[wr_ptr_p1] <= bus.in_instr_b;
        pc_mem[wr_ptr_p1]    <= bus.in_pc_b;
      end
    end
  end

  always_comb begin
    bus.out_valid_a = 1'b0;
    bus.out_instr_a = NOP_INSTR;
    bus.out_pc_a    = '0;
    bus.out_valid_b = 1'b0;
    bus.out_instr_b = NOP_INSTR;
    bus.out_pc_b    = '0;
    if (count_q >= CW'(1)) begin
      bus.out_valid_a = 1'b1;
      bus.out_instr_a = instr_mem[rd_ptr];
      bus.out_pc_a    = pc_mem[rd_ptr];
    end
    if (count_q >= CW'(2)) begin
      bus.out_valid_b = 1'b1;
      bus.out_instr_b = instr_mem[rd_ptr_p1];
      bus.out_pc_b    = pc_mem[rd_ptr_p1];
    end
  end

  assign bus.in_ready = ready;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_dual_fetch_queue.sv
// Bench for dual_fetch_queue: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_dual_fetch_queue;
  localparam int          DEPTH = 8;
  localparam int          XLEN  = 32;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dual_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  dual_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    logic        f;
    logic        va;
    logic [31:0] pa;
    logic        vb;
    logic [31:0] pb;
    logic [1:0]  pop;
    int          exp_count;
    logic        exp_va;
    logic        exp_vb;
    logic [31:0] exp_pa;
    logic [31:0] exp_pb;
    logic        exp_ready;
  } vec_t;

  entry_t model_q[$];
  vec_t   vecs[$];
  int     checks_total  = 0;
  int     checks_passed = 0;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    if (pc == 32'h0) return 32'h00500093;
    if (pc == 32'h4) return 32'h00A00113;
    return 32'hC0DE0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add_vec(input logic f, input logic va, input logic [31:0] pa,
                         input logic vb, input logic [31:0] pb, input logic [1:0] pop,
                         input int ec, input logic eva, input logic evb,
                         input logic [31:0] epa, input logic [31:0] epb, input logic er);
    vec_t v;
    v.f = f; v.va = va; v.pa = pa; v.vb = vb; v.pb = pb; v.pop = pop;
    v.exp_count = ec; v.exp_va = eva; v.exp_vb = evb;
    v.exp_pa = epa; v.exp_pb = epb; v.exp_ready = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic f, input logic va, input logic [31:0] ia, input logic [31:0] pa,
                       input logic vb, input logic [31:0] ib, input logic [31:0] pb,
                       input logic [1:0] pop);
    bus.flush      = f;
    bus.in_valid_a = va;
    bus.in_instr_a = ia;
    bus.in_pc_a    = pa;
    bus.in_valid_b = vb;
    bus.in_instr_b = ib;
    bus.in_pc_b    = pb;
    bus.pop_cnt    = pop;
  endtask

  // Reference behaviour: oldest-first queue, pops taken from the front, pushes appended.
  task automatic model_update(input logic f, input logic va, input logic [31:0] ia, input logic [31:0] pa,
                              input logic vb, input logic [31:0] ib, input logic [31:0] pb,
                              input logic [1:0] pop);
    entry_t e;
    int     p;
    bit     rdy;
    rdy = (DEPTH - model_q.size()) >= 2;
    if (f) begin
      model_q.delete();
    end else begin
      p = (pop == 2'd3) ? 2 : int'(pop);
      if (p > model_q.size()) p = model_q.size();
      repeat (p) void'(model_q.pop_front());
      if (rdy) begin
        if (va) begin e.instr = ia; e.pc = pa; model_q.push_back(e); end
        if (vb) begin e.instr = ib; e.pc = pb; model_q.push_back(e); end
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic apply_stimulus(input logic f, input logic va, input logic [31:0] ia, input logic [31:0] pa,
                                input logic vb, input logic [31:0] ib, input logic [31:0] pb,
                                input logic [1:0] pop);
    drive(f, va, ia, pa, vb, ib, pb, pop);
    model_update(f, va, ia, pa, vb, ib, pb, pop);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input string tag);
    int n;
    n = model_q.size();
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'((DEPTH - n) >= 2));
    chk({tag, ".valid_a"}, 32'(bus.out_valid_a), 32'(n >= 1));
    chk({tag, ".valid_b"}, 32'(bus.out_valid_b), 32'(n >= 2));
    chk({tag, ".instr_a"}, bus.out_instr_a, (n >= 1) ? model_q[0].instr : NOP);
    chk({tag, ".pc_a"},    bus.out_pc_a,    (n >= 1) ? model_q[0].pc    : 32'h0);
    chk({tag, ".instr_b"}, bus.out_instr_b, (n >= 2) ? model_q[1].instr : NOP);
    chk({tag, ".pc_b"},    bus.out_pc_b,    (n >= 2) ? model_q[1].pc    : 32'h0);
  endtask

  initial begin
    logic [31:0] pc;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset.count", 32'(bus.count), 32'd0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset.valid_a", 32'(bus.out_valid_a), 32'd0);
    chk("reset.valid_b", 32'(bus.out_valid_b), 32'd0);
    chk("reset.instr_a", bus.out_instr_a, NOP);
    chk("reset.instr_b", bus.out_instr_b, NOP);
    chk("reset.pc_a", bus.out_pc_a, 32'h0);
    chk("reset.pc_b", bus.out_pc_b, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors (DEPTH = 8)
    add_vec(0, 1, 32'h00, 1, 32'h04, 2'd0, 2, 1, 1, 32'h00, 32'h04, 1);
    add_vec(0, 1, 32'h08, 1, 32'h0C, 2'd0, 4, 1, 1, 32'h00, 32'h04, 1);
    add_vec(0, 1, 32'h10, 1, 32'h14, 2'd0, 6, 1, 1, 32'h00, 32'h04, 1);
    add_vec(0, 1, 32'h18, 1, 32'h1C, 2'd0, 8, 1, 1, 32'h00, 32'h04, 0);
    add_vec(0, 1, 32'h20, 1, 32'h24, 2'd0, 8, 1, 1, 32'h00, 32'h04, 0);
    add_vec(0, 0, 32'h00, 0, 32'h00, 2'd2, 6, 1, 1, 32'h08, 32'h0C, 1);
    add_vec(0, 0, 32'h00, 0, 32'h00, 2'd3, 4, 1, 1, 32'h10, 32'h14, 1);
    add_vec(0, 1, 32'h40, 1, 32'h44, 2'd1, 5, 1, 1, 32'h14, 32'h18, 1);
    add_vec(1, 1, 32'h50, 1, 32'h54, 2'd1, 0, 0, 0, 32'h00, 32'h00, 1);
    add_vec(0, 1, 32'h100, 0, 32'h00, 2'd0, 1, 1, 0, 32'h100, 32'h00, 1);
    add_vec(0, 0, 32'h00, 0, 32'h00, 2'd2, 0, 0, 0, 32'h00, 32'h00, 1);
    add_vec(0, 0, 32'h00, 1, 32'h20, 2'd0, 1, 1, 0, 32'h20, 32'h00, 1);
    add_vec(0, 1, 32'h24, 0, 32'h00, 2'd0, 2, 1, 1, 32'h20, 32'h24, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].f, vecs[i].va, ins(vecs[i].pa), vecs[i].pa,
            vecs[i].vb, ins(vecs[i].pb), vecs[i].pb, vecs[i].pop);
      #1;
      if (i == 0) begin
        chk("nobypass.valid_a", 32'(bus.out_valid_a), 32'd0);
        chk("nobypass.instr_a", bus.out_instr_a, NOP);
      end
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d.count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d.valid_a", i), 32'(bus.out_valid_a), 32'(vecs[i].exp_va));
      chk($sformatf("vec%0d.valid_b", i), 32'(bus.out_valid_b), 32'(vecs[i].exp_vb));
      chk($sformatf("vec%0d.pc_a", i), bus.out_pc_a, vecs[i].exp_pa);
      chk($sformatf("vec%0d.pc_b", i), bus.out_pc_b, vecs[i].exp_pb);
      chk($sformatf("vec%0d.instr_a", i), bus.out_instr_a, vecs[i].exp_va ? ins(vecs[i].exp_pa) : NOP);
      chk($sformatf("vec%0d.instr_b", i), bus.out_instr_b, vecs[i].exp_vb ? ins(vecs[i].exp_pb) : NOP);
    end

    // Asynchronous reset between clock edges, held across an edge with a push pending
    drive(1'b0, 1'b1, 32'h11111111, 32'h300, 1'b1, 32'h22222222, 32'h304, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async.count", 32'(bus.count), 32'd0);
    chk("async.valid_a", 32'(bus.out_valid_a), 32'd0);
    chk("async.instr_a", bus.out_instr_a, NOP);
    chk("async.pc_a", bus.out_pc_a, 32'h0);
    chk("async.in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("async_hold.count", 32'(bus.count), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0);
    rst_n = 1'b1;
    model_q.delete();
    @(negedge clk);
    check_output("post_reset");

    // Steady push2/pop2 across pointer wrap
    pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, $urandom, pc, 1'b1, $urandom, pc + 32'h4, 2'd0);
      pc += 32'h8;
    end
    check_output("fill6");
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b0, 1'b1, $urandom, pc, 1'b1, $urandom, pc + 32'h4, 2'd2);
      pc += 32'h8;
      check_output($sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d.order", k), bus.out_pc_a, 32'h200 + 32'(8 * (k + 1)));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 15) == 0), 1'($urandom), $urandom, $urandom,
                     1'($urandom), $urandom, $urandom, 2'($urandom));
      check_output($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
